// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and the
// oversampling divider calculation.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_t;

   // Clock cycles per oversampling tick, floored, never below one.
   function automatic int calc_div(input int clk_freq, input int baud_rate, input int os_rate);
      int d;
      d = clk_freq / (baud_rate * os_rate);
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, byte handshake and status out.
interface uart_rx_if;

   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   modport slave (
      input  rx,
      input  rx_ready,
      output rx_data,
      output rx_valid,
      output frame_err,
      output overrun,
      output busy
   );

   modport master (
      output rx,
      output rx_ready,
      input  rx_data,
      input  rx_valid,
      input  frame_err,
      input  overrun,
      input  busy
   );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: counts 0..DIV-1 and pulses tick on the last
// count; clear restarts the count so sampling can be phased to a start edge.
module uart_baud_tick #(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clear || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes rx, finds the start edge, samples each bit at
// its middle using oversampling ticks, and presents bytes on a valid/ready port.
module uart_rx
   import uart_pkg::*;
#(
   parameter int clk_freq  = 1000000,
   parameter int baud_rate = 9600,
   parameter int os_rate   = 16
) (
   input logic      clk,
   input logic      rst,
   uart_rx_if.slave bus
);

   localparam int DIV = calc_div(clk_freq, baud_rate, os_rate);
   localparam int TW  = (os_rate > 1) ? $clog2(os_rate) : 1;
   localparam int MID = (os_rate / 2 > 0) ? (os_rate / 2 - 1) : 0;
   localparam logic [TW-1:0] TICK_MID  = TW'(MID);
   localparam logic [TW-1:0] TICK_LAST = TW'(os_rate - 1);

   logic          rx_meta, rx_sync, rx_prev;
   logic          start_edge;
   logic          tick, tick_clear;
   uart_state_t   state, state_nxt;
   logic [TW-1:0] tick_cnt, tick_cnt_nxt;
   logic [2:0]    bit_idx, bit_idx_nxt;
   logic [7:0]    shift, shift_nxt;
   logic          complete, frame_bad;
   logic [7:0]    data_q;
   logic          valid_q, ferr_q, ovr_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= bus.rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   assign start_edge = rx_prev & ~rx_sync;

   uart_baud_tick #(.DIV(DIV)) u_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (tick_clear),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         tick_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
      end else begin
         state    <= state_nxt;
         tick_cnt <= tick_cnt_nxt;
         bit_idx  <= bit_idx_nxt;
         shift    <= shift_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      tick_cnt_nxt = tick_cnt;
      bit_idx_nxt  = bit_idx;
      shift_nxt    = shift;
      tick_clear   = 1'b0;
      complete     = 1'b0;
      frame_bad    = 1'b0;
      case (state)
         IDLE: begin
            if (start_edge) begin
               state_nxt    = START;
               tick_cnt_nxt = '0;
               tick_clear   = 1'b1;
            end
         end
         START: begin
            if (tick) begin
               if (tick_cnt == TICK_MID) begin
                  // A line already back high at mid start bit was only a glitch.
                  if (!rx_sync) begin
                     state_nxt    = DATA;
                     tick_cnt_nxt = '0;
                     bit_idx_nxt  = '0;
                  end else begin
                     state_nxt = IDLE;
                  end
               end else begin
                  tick_cnt_nxt = tick_cnt + 1'b1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (tick_cnt == TICK_LAST) begin
                  tick_cnt_nxt = '0;
                  shift_nxt    = {rx_sync, shift[7:1]};
                  bit_idx_nxt  = bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     state_nxt = STOP;
                  end
               end else begin
                  tick_cnt_nxt = tick_cnt + 1'b1;
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (tick_cnt == TICK_LAST) begin
                  state_nxt    = IDLE;
                  tick_cnt_nxt = '0;
                  complete     = rx_sync;
                  frame_bad    = ~rx_sync;
               end else begin
                  tick_cnt_nxt = tick_cnt + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A byte completing while the previous one is being accepted replaces it
   // without a gap in rx_valid; otherwise an unconsumed byte wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         ferr_q <= frame_bad;
         ovr_q  <= 1'b0;
         if (complete) begin
            if (!valid_q || bus.rx_ready) begin
               data_q  <= shift;
               valid_q <= 1'b1;
            end else begin
               ovr_q <= 1'b1;
            end
         end else if (valid_q && bus.rx_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign bus.rx_data   = data_q;
   assign bus.rx_valid  = valid_q;
   assign bus.frame_err = ferr_q;
   assign bus.overrun   = ovr_q;
   assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are driven bit by bit and
// accepted bytes are matched against a queue of expected bytes.
module tb_uart_rx;

   localparam int CLK_FREQ = 1536000;
   localparam int BAUD     = 9600;
   localparam int OS       = 16;
   localparam int BIT_CLKS = 160;

   logic clk = 1'b0;
   logic rst = 1'b0;

   uart_rx_if bus ();

   uart_rx #(
      .clk_freq  (CLK_FREQ),
      .baud_rate (BAUD),
      .os_rate   (OS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [7:0] expQ[$];
   logic [7:0] gotQ[$];
   int checks   = 0;
   int failures = 0;
   int ferrCnt  = 0;
   int ovrCnt   = 0;
   int riseCnt  = 0;
   int highCnt  = 0;
   int dropCnt  = 0;
   bit watchDrop = 1'b0;
   logic prevValid = 1'b0;

   // Observes the port just after each falling edge, once the bench's own
   // input changes for the coming rising edge have settled.
   always @(negedge clk) begin
      #1;
      if (rst) begin
         if (bus.rx_valid && bus.rx_ready) gotQ.push_back(bus.rx_data);
         if (bus.frame_err) ferrCnt++;
         if (bus.overrun) ovrCnt++;
         if (bus.rx_valid) highCnt++;
         if (bus.rx_valid && !prevValid) riseCnt++;
         if (watchDrop && !bus.rx_valid) dropCnt++;
         prevValid = bus.rx_valid;
      end else begin
         prevValid = 1'b0;
      end
   end

   task automatic applyStimulus(input logic [7:0] d, input logic stopBit);
      bus.rx = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         bus.rx = d[i];
         repeat (BIT_CLKS) @(negedge clk);
      end
      bus.rx = stopBit;
      repeat (BIT_CLKS) @(negedge clk);
      bus.rx = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.rx = 1'b1;
      bus.rx_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.rx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_rx_data got=%h exp=00", bus.rx_data); end
      checks++;
      if (bus.rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rx_valid got=%b exp=0", bus.rx_valid); end
      checks++;
      if (bus.frame_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_err got=%b exp=0", bus.frame_err); end
      checks++;
      if (bus.overrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_overrun got=%b exp=0", bus.overrun); end
      checks++;
      if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy); end
      rst = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_after_release_busy got=%b exp=0", bus.busy); end
   endtask

   task automatic test_basic();
      int f0, o0, r0, h0;
      logic [7:0] gotB, expB;
      f0 = ferrCnt; o0 = ovrCnt; r0 = riseCnt; h0 = highCnt;
      bus.rx_ready = 1'b1;
      expQ.push_back(8'hA5);
      applyStimulus(8'hA5, 1'b1);
      repeat (40) @(negedge clk);
      checks++;
      if (riseCnt - r0 !== 1) begin failures++; $display("[TB] FAIL basic_valid_rises got=%0d exp=1", riseCnt - r0); end
      checks++;
      if (highCnt - h0 !== 1) begin failures++; $display("[TB] FAIL basic_valid_width got=%0d exp=1", highCnt - h0); end
      checks++;
      if (ferrCnt - f0 !== 0) begin failures++; $display("[TB] FAIL basic_frame_err got=%0d exp=0", ferrCnt - f0); end
      checks++;
      if (ovrCnt - o0 !== 0) begin failures++; $display("[TB] FAIL basic_overrun got=%0d exp=0", ovrCnt - o0); end
      checks++;
      if (gotQ.size() != expQ.size()) begin
         failures++; $display("[TB] FAIL basic_sb_count got=%0d exp=%0d", gotQ.size(), expQ.size());
         gotQ.delete(); expQ.delete();
      end else while (expQ.size() > 0) begin
         expB = expQ.pop_front(); gotB = gotQ.pop_front(); checks++;
         if (gotB !== expB) begin failures++; $display("[TB] FAIL basic_data got=%h exp=%h", gotB, expB); end
      end
   endtask

   task automatic test_glitch();
      int r0, f0;
      logic [7:0] gotB, expB;
      r0 = riseCnt; f0 = ferrCnt;
      bus.rx = 1'b0;
      repeat (30) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL glitch_busy_during got=%b exp=1", bus.busy); end
      repeat (20) @(negedge clk);
      bus.rx = 1'b1;
      repeat (200) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL glitch_busy_after got=%b exp=0", bus.busy); end
      checks++;
      if (riseCnt - r0 !== 0 || ferrCnt - f0 !== 0) begin
         failures++; $display("[TB] FAIL glitch_outputs valid=%0d ferr=%0d exp=0/0", riseCnt - r0, ferrCnt - f0);
      end
      expQ.push_back(8'h3C);
      applyStimulus(8'h3C, 1'b1);
      repeat (40) @(negedge clk);
      checks++;
      if (gotQ.size() != expQ.size()) begin
         failures++; $display("[TB] FAIL glitch_sb_count got=%0d exp=%0d", gotQ.size(), expQ.size());
         gotQ.delete(); expQ.delete();
      end else while (expQ.size() > 0) begin
         expB = expQ.pop_front(); gotB = gotQ.pop_front(); checks++;
         if (gotB !== expB) begin failures++; $display("[TB] FAIL glitch_data got=%h exp=%h", gotB, expB); end
      end
   endtask

   task automatic test_frame_err();
      int r0, f0;
      logic [7:0] gotB, expB;
      r0 = riseCnt; f0 = ferrCnt;
      applyStimulus(8'h5A, 1'b0);
      repeat (40) @(negedge clk);
      checks++;
      if (ferrCnt - f0 !== 1) begin failures++; $display("[TB] FAIL ferr_pulses got=%0d exp=1", ferrCnt - f0); end
      checks++;
      if (riseCnt - r0 !== 0) begin failures++; $display("[TB] FAIL ferr_valid got=%0d exp=0", riseCnt - r0); end
      checks++;
      if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL ferr_busy got=%b exp=0", bus.busy); end
      expQ.push_back(8'h96);
      applyStimulus(8'h96, 1'b1);
      repeat (40) @(negedge clk);
      checks++;
      if (gotQ.size() != expQ.size()) begin
         failures++; $display("[TB] FAIL ferr_sb_count got=%0d exp=%0d", gotQ.size(), expQ.size());
         gotQ.delete(); expQ.delete();
      end else while (expQ.size() > 0) begin
         expB = expQ.pop_front(); gotB = gotQ.pop_front(); checks++;
         if (gotB !== expB) begin failures++; $display("[TB] FAIL ferr_data got=%h exp=%h", gotB, expB); end
      end
   endtask

   task automatic test_overrun();
      int o0, f0;
      logic [7:0] gotB, expB;
      bus.rx_ready = 1'b0;
      o0 = ovrCnt; f0 = ferrCnt;
      expQ.push_back(8'h11);
      applyStimulus(8'h11, 1'b1);
      repeat (40) @(negedge clk);
      checks++;
      if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h11) begin
         failures++; $display("[TB] FAIL ovr_first valid=%b data=%h exp=1/11", bus.rx_valid, bus.rx_data);
      end
      applyStimulus(8'h22, 1'b1);
      repeat (40) @(negedge clk);
      checks++;
      if (bus.rx_data !== 8'h11) begin failures++; $display("[TB] FAIL ovr_held_data got=%h exp=11", bus.rx_data); end
      checks++;
      if (bus.rx_valid !== 1'b1) begin failures++; $display("[TB] FAIL ovr_valid got=%b exp=1", bus.rx_valid); end
      checks++;
      if (ovrCnt - o0 !== 1) begin failures++; $display("[TB] FAIL ovr_pulses got=%0d exp=1", ovrCnt - o0); end
      checks++;
      if (ferrCnt - f0 !== 0) begin failures++; $display("[TB] FAIL ovr_frame_err got=%0d exp=0", ferrCnt - f0); end
      bus.rx_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL ovr_valid_clear got=%b exp=0", bus.rx_valid); end
      checks++;
      if (gotQ.size() != expQ.size()) begin
         failures++; $display("[TB] FAIL ovr_sb_count got=%0d exp=%0d", gotQ.size(), expQ.size());
         gotQ.delete(); expQ.delete();
      end else while (expQ.size() > 0) begin
         expB = expQ.pop_front(); gotB = gotQ.pop_front(); checks++;
         if (gotB !== expB) begin failures++; $display("[TB] FAIL ovr_data got=%h exp=%h", gotB, expB); end
      end
   endtask

   task automatic test_back_to_back();
      int o0, d0;
      logic [7:0] gotB, expB;
      bus.rx_ready = 1'b0;
      expQ.push_back(8'h44);
      applyStimulus(8'h44, 1'b1);
      repeat (40) @(negedge clk);
      expQ.push_back(8'h55);
      o0 = ovrCnt; d0 = dropCnt;
      watchDrop = 1'b1;
      // Start edge is seen two cycles after rx falls; the stop-bit sample
      // lands 1522 falling edges after the frame starts.
      fork
         applyStimulus(8'h55, 1'b1);
         begin
            repeat (1522) @(negedge clk);
            bus.rx_ready = 1'b1;
            @(negedge clk);
            bus.rx_ready = 1'b0;
         end
      join
      repeat (40) @(negedge clk);
      watchDrop = 1'b0;
      checks++;
      if (bus.rx_data !== 8'h55) begin failures++; $display("[TB] FAIL b2b_data got=%h exp=55", bus.rx_data); end
      checks++;
      if (bus.rx_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_valid got=%b exp=1", bus.rx_valid); end
      checks++;
      if (ovrCnt - o0 !== 0) begin failures++; $display("[TB] FAIL b2b_overrun got=%0d exp=0", ovrCnt - o0); end
      checks++;
      if (dropCnt - d0 !== 0) begin failures++; $display("[TB] FAIL b2b_valid_gap got=%0d exp=0", dropCnt - d0); end
      bus.rx_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (gotQ.size() != expQ.size()) begin
         failures++; $display("[TB] FAIL b2b_sb_count got=%0d exp=%0d", gotQ.size(), expQ.size());
         gotQ.delete(); expQ.delete();
      end else while (expQ.size() > 0) begin
         expB = expQ.pop_front(); gotB = gotQ.pop_front(); checks++;
         if (gotB !== expB) begin failures++; $display("[TB] FAIL b2b_data_order got=%h exp=%h", gotB, expB); end
      end
   endtask

   task automatic test_reset_midframe();
      int r0;
      logic [7:0] gotB, expB;
      bus.rx_ready = 1'b1;
      bus.rx = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      bus.rx = 1'b1;
      repeat (4 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_busy_before got=%b exp=1", bus.busy); end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (bus.rx_data !== 8'h00 || bus.rx_valid !== 1'b0) begin
         failures++; $display("[TB] FAIL rstmid_data data=%h valid=%b exp=00/0", bus.rx_data, bus.rx_valid);
      end
      checks++;
      if (bus.busy !== 1'b0 || bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin
         failures++; $display("[TB] FAIL rstmid_status busy=%b ferr=%b ovr=%b exp=0/0/0", bus.busy, bus.frame_err, bus.overrun);
      end
      @(negedge clk);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      r0 = riseCnt;
      repeat (800) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || riseCnt - r0 !== 0) begin
         failures++; $display("[TB] FAIL rstmid_after busy=%b valid=%0d exp=0/0", bus.busy, riseCnt - r0);
      end
      expQ.push_back(8'h81);
      applyStimulus(8'h81, 1'b1);
      repeat (40) @(negedge clk);
      checks++;
      if (gotQ.size() != expQ.size()) begin
         failures++; $display("[TB] FAIL rstmid_sb_count got=%0d exp=%0d", gotQ.size(), expQ.size());
         gotQ.delete(); expQ.delete();
      end else while (expQ.size() > 0) begin
         expB = expQ.pop_front(); gotB = gotQ.pop_front(); checks++;
         if (gotB !== expB) begin failures++; $display("[TB] FAIL rstmid_data_next got=%h exp=%h", gotB, expB); end
      end
   endtask

   initial begin
      bus.rx = 1'b1;
      bus.rx_ready = 1'b1;
      @(negedge clk);
      test_reset();
      test_basic();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_back_to_back();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: clk_freq, default 1000000, system clock frequency in Hz.
REQ-002 Parameter: baud_rate, default 9600, serial bit rate in bits per second.
REQ-003 Parameter: os_rate, default 16, oversampling ticks per bit.
REQ-004 The design SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  system clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous reset, active-low.
REQ-007 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-008 rx_data  output  8  received byte.
REQ-009 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-010 rx_ready  input  1  consumer accepts the byte when rx_valid && rx_ready.
REQ-011 frame_err  output  1  one-cycle pulse; the stop bit was sampled low.
REQ-012 overrun  output  1  one-cycle pulse; a completed byte was dropped.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer before any use; the edge detector SHALL compare the synchronized value against its 1-cycle delayed copy.
REQ-015 Tick divider: DIV = clk_freq/(baud_rate*os_rate), integer floor, minimum 1; counter runs 0..DIV-1 and emits a one-cycle tick at DIV-1.
REQ-016 The tick divider SHALL be cleared to 0 on the cycle a start edge is detected in IDLE, aligning sampling to the edge.
REQ-017 FSM states SHALL be IDLE, START, DATA, STOP; reset state is IDLE.
REQ-018 IDLE: on a synchronized 1->0 transition, go to START with tick count = 0; a line held low SHALL NOT retrigger.
REQ-019 START: at tick count os_rate/2-1 (mid start bit), if rx is 0 go to DATA with bit index 0 and tick count 0; if rx is 1 (glitch), return to IDLE with no outputs.
REQ-020 DATA: every os_rate ticks (mid-bit), shift the sampled rx into the shift register LSB-first; after bit index 7 is sampled, go to STOP.
REQ-021 STOP: at mid stop bit, rx = 1 SHALL complete the byte; rx = 0 SHALL pulse frame_err for 1 cycle, discard the byte, and return to IDLE.
REQ-022 Completion SHALL return to IDLE in the same cycle; rx_valid SHALL rise on the next clk edge after the mid-stop sample.
REQ-023 rx_data SHALL be stable while rx_valid is high; rx_valid SHALL clear on the cycle after rx_valid && rx_ready.
REQ-024 Completion while rx_valid = 1 and rx_ready = 0: pulse overrun for 1 cycle, keep the old rx_data, drop the new byte.
REQ-025 Completion in the same cycle as acceptance (rx_valid && rx_ready): load the new byte, and rx_valid SHALL stay high with no overrun.

Reset
REQ-026 Asserting rst low SHALL immediately force IDLE, rx_data = 8'h00, rx_valid = 0, frame_err = 0, overrun = 0, busy = 0, all counters = 0, and synchronizer flops = 1.
REQ-027 Reset mid-frame SHALL abort the frame; after release the block SHALL wait for a new 1->0 edge.

Structure
REQ-028 A shared package uart_pkg SHALL hold the state enum (IDLE, START, DATA, STOP) and the DIV computation function, for reuse by the transmitter.
REQ-029 One sub-module, uart_baud_tick (divider with synchronous clear, tick output), SHALL be instantiated; the FSM, synchronizer and output register SHALL stay in uart_rx.

Verification (clk_freq = 1536000, baud_rate = 9600, os_rate = 16, so DIV = 10 and 1 bit = 160 clk)
REQ-030 Frame 0x A5 (start, 1,0,1,0,0,1,0,1, stop) with rx_ready held high -> rx_valid pulses 1 cycle with rx_data = 0xA5, no error pulses.
REQ-031 rx low for 50 clk, then high -> no rx_valid, busy returns to 0, and a following frame 0x3C is received correctly.
REQ-032 Frame 0x5A with the stop bit driven 0 -> frame_err pulses once, rx_valid stays 0, and a later frame is received correctly.
REQ-033 rx_ready = 0; frames 0x11 then 0x22 -> rx_data = 0x11 held, overrun pulses once at the second stop bit, rx_valid stays 1.
REQ-034 rst driven low at bit 4 of frame 0xFF -> outputs at reset values immediately; the next frame 0x81 is received correctly.
REQ-035 rx_ready pulsed in the cycle the next byte completes -> new byte loaded, rx_valid remains 1, overrun = 0.
